// File: rtl/l2g_chain_sequencer.sv
// l2g_chain_sequencer: derives a glitch-free global clock from the fabric clock, drives an LFSR
// pattern into an external register chain clocked by that global net, and checks the chain tail
// against a delayed copy of the pattern. All outputs come straight from registers.
module l2g_chain_sequencer #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned NPULSE = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_seed,
  output logic       o_gclk_out,
  output logic       o_d_out,
  input  logic       i_q_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_err_count
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW = $clog2(NPULSE + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(NPULSE);
  localparam logic [PW-1:0] CMP_FIRST  = PW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [7:0]       r_seed;
  logic [7:0]       r_lfsr;
  logic [DW-1:0]    r_divcnt;
  logic [PW-1:0]    r_pulse_cnt;
  logic [DEPTH-1:0] r_hist;
  logic [7:0]       r_err;
  logic             r_gclk;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_accept;
  logic             w_load;
  logic             w_run;
  logic             w_wrap;
  logic             w_rise;
  logic             w_fall;
  logic             w_cmp;
  logic             w_mismatch;
  logic             w_last;
  logic [7:0]       w_seed_fix;
  logic [7:0]       w_lfsr_step;
  logic [7:0]       w_err_inc;
  logic [7:0]       w_err_next;
  logic [DEPTH-1:0] w_hist_shift;

  // Event decode: divider wrap splits into rising/falling toggles of the derived clock.
  always_comb begin
    w_accept     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_load       = (r_state == ST_LOAD);
    w_run        = (r_state == ST_RUN);
    w_wrap       = w_run && (r_divcnt == DIV_LAST);
    w_rise       = w_wrap && !r_gclk;
    w_fall       = w_wrap && r_gclk;
    // The tail only carries pattern data once DEPTH rising edges have filled the chain.
    w_cmp        = w_fall && (r_pulse_cnt >= CMP_FIRST);
    w_mismatch   = w_cmp && (i_q_in != r_hist[DEPTH-1]);
    w_last       = w_fall && (r_pulse_cnt == PULSE_LAST);
    w_seed_fix   = (r_seed == 8'h00) ? 8'h01 : r_seed;
    // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    w_lfsr_step  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_err_inc    = (r_err == 8'hFF) ? r_err : (r_err + 8'd1);
    w_err_next   = w_mismatch ? w_err_inc : r_err;
    w_hist_shift = {r_hist[DEPTH-2:0], r_dout};
  end

  // Sequencer state: IDLE/DONE accept start, LOAD lasts one cycle, RUN ends on the last fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) r_state <= ST_LOAD;
        ST_LOAD: r_state <= ST_RUN;
        ST_RUN:  if (w_last) r_state <= ST_RUN + 2'd1;
        ST_DONE: if (i_start) r_state <= ST_LOAD;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Seed capture on an accepted start; used by LOAD on the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seed <= 8'h00;
    end else if (w_accept) begin
      r_seed <= i_seed;
    end
  end

  // Half-period divider; only counts in RUN so the first toggle lands DIV cycles after LOAD.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_load) begin
      r_divcnt <= '0;
    end else if (w_run) begin
      r_divcnt <= w_wrap ? '0 : (r_divcnt + DW'(1));
    end
  end

  // Derived clock: registered toggle, forced low by reset and LOAD, held low in IDLE/DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_load) begin
      r_gclk <= 1'b0;
    end else if (w_wrap) begin
      r_gclk <= ~r_gclk;
    end
  end

  // Rising-edge bookkeeping: pulse count and a model of what the chain has captured.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_load) begin
      r_pulse_cnt <= '0;
      r_hist      <= '0;
    end else if (w_rise) begin
      r_pulse_cnt <= r_pulse_cnt + PW'(1);
      r_hist      <= w_hist_shift;
    end
  end

  // Pattern source: data moves on the falling toggle, half a period from the capturing edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 8'h01;
      r_dout <= 1'b0;
    end else if (w_load) begin
      r_lfsr <= w_seed_fix;
      r_dout <= w_seed_fix[0];
    end else if (w_fall) begin
      r_lfsr <= w_lfsr_step;
      r_dout <= w_lfsr_step[0];
    end
  end

  // Saturating mismatch counter; cleared only by reset and LOAD so it survives DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_load) begin
      r_err <= 8'h00;
    end else begin
      r_err <= w_err_next;
    end
  end

  // Status flags, registered alongside the state transitions that define them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_last) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
      r_pass <= (w_err_next == 8'h00);
    end
  end

  assign o_gclk_out  = r_gclk;
  assign o_d_out     = r_dout;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;

endmodule

// File: tb/tb_l2g_chain_sequencer.sv
// Bench for l2g_chain_sequencer: external chain modelled on the derived clock, directed table of
// runs, hand-written reset/start corner sequences and randomized runs against a pattern model.
module tb_l2g_chain_sequencer;

  localparam int DIV    = 4;
  localparam int DEPTH  = 5;
  localparam int NPULSE = 64;
  localparam int RUN_LAT = 2 * DIV * NPULSE + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic       gclk;
  logic       d_out;
  logic       q_in;
  logic       busy;
  logic       done;
  logic       pass_o;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  // External chain model and run observation.
  logic [7:0]   chain = 8'h00;
  logic [2:0]   tail_idx = 3'd4;
  logic         chain_inv = 1'b0;
  logic [127:0] flip_mask = '0;
  logic [127:0] obs_seq = '0;
  logic [127:0] model_seq = '0;
  int           rise_cnt = 0;

  // Phase-width tracker state.
  logic ph_prev;
  int   ph_len = 0;
  bit   ph_seen_fall = 1'b0;

  typedef struct {
    logic [7:0] seed;
    int         len;
    bit         inv;
    int         exp_err;   // -1: any nonzero count
    bit         exp_pass;
  } vec_t;

  vec_t vec[6];

  l2g_chain_sequencer #(
    .DIV    (DIV),
    .DEPTH  (DEPTH),
    .NPULSE (NPULSE)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_seed      (seed),
    .o_gclk_out  (gclk),
    .o_d_out     (d_out),
    .i_q_in      (q_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass_o),
    .o_err_count (err_count)
  );

  always #5 clk = ~clk;

  assign q_in = chain[tail_idx] ^ chain_inv ^ flip_mask[rise_cnt[6:0]];

  always @(posedge gclk) begin
    chain <= {chain[6:0], d_out};
    rise_cnt = rise_cnt + 1;
    if (rise_cnt < 128) obs_seq[rise_cnt[6:0]] = d_out;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every complete high and low phase inside a run must last exactly DIV clk cycles.
  always @(negedge clk) begin
    if (busy === 1'b0) begin
      ph_prev      = gclk;
      ph_len       = 0;
      ph_seen_fall = 1'b0;
    end else if (gclk === ph_prev) begin
      ph_len++;
    end else begin
      if (gclk === 1'b0) begin
        check("high_phase", ph_len, DIV);
        ph_seen_fall = 1'b1;
      end else if (ph_seen_fall) begin
        check("low_phase", ph_len, DIV);
      end
      ph_prev = gclk;
      ph_len  = 1;
    end
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Value presented on d_out at each rising edge k (1..NPULSE).
  task automatic build_model(input logic [7:0] s);
    logic [7:0] v;
    v = (s == 8'h00) ? 8'h01 : s;
    model_seq = '0;
    for (int k = 1; k <= NPULSE; k++) begin
      model_seq[k] = v[0];
      v = lfsr_next(v);
    end
  endtask

  // A chain of len flops shows the value launched at rise k-len+1 after rise k; the checker
  // expects the value from rise k-DEPTH+1.
  function automatic int model_err(input int len, input bit inv, input logic [127:0] flips);
    int n = 0;
    for (int k = DEPTH; k <= NPULSE; k++)
      if ((model_seq[k-len+1] ^ inv ^ flips[k]) != model_seq[k-DEPTH+1]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic do_run(input logic [7:0] s, input int len, input bit inv,
                        input logic [127:0] flips, input int poke_at,
                        output int lat, output logic [7:0] err_v, output logic pass_v);
    tail_idx  = 3'(len - 1);
    chain_inv = inv;
    flip_mask = flips;
    rise_cnt  = 0;
    obs_seq   = '0;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("done_drop", done, 0);
    @(negedge clk);
    check("err_clear_load", err_count, 0);
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    err_v  = err_count;
    pass_v = pass_o;
  endtask

  task automatic check_run(input string tag, input int lat, input logic [7:0] err_v,
                           input logic pass_v, input int exp_e);
    check({tag, "_latency"}, lat, RUN_LAT);
    check({tag, "_rises"}, rise_cnt, NPULSE);
    check({tag, "_dseq"}, obs_seq, model_seq);
    check({tag, "_err_model"}, err_v, exp_e);
    check({tag, "_pass_model"}, pass_v, (exp_e == 0));
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_gclk_low"}, gclk, 0);
  endtask

  initial begin
    int           lat;
    int           exp_e;
    logic [7:0]   err_v;
    logic         pass_v;
    logic [127:0] flips;
    int           len;
    bit           inv;
    logic [7:0]   s;

    vec[0] = '{seed: 8'hA5, len: 5, inv: 1'b0, exp_err: 0,  exp_pass: 1'b1};
    vec[1] = '{seed: 8'hA5, len: 5, inv: 1'b1, exp_err: 60, exp_pass: 1'b0};
    vec[2] = '{seed: 8'h00, len: 5, inv: 1'b0, exp_err: 0,  exp_pass: 1'b1};
    vec[3] = '{seed: 8'h01, len: 5, inv: 1'b0, exp_err: 0,  exp_pass: 1'b1};
    vec[4] = '{seed: 8'hA5, len: 4, inv: 1'b0, exp_err: -1, exp_pass: 1'b0};
    vec[5] = '{seed: 8'hA5, len: 5, inv: 1'b0, exp_err: 0,  exp_pass: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    seed  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_gclk", gclk, 0);
    check("rst_dout", d_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_o, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; row 5 restarts straight from the DONE left by the short-chain row.
    for (int r = 0; r < 6; r++) begin
      build_model(vec[r].seed);
      exp_e = model_err(vec[r].len, vec[r].inv, '0);
      do_run(vec[r].seed, vec[r].len, vec[r].inv, '0, -1, lat, err_v, pass_v);
      check_run($sformatf("tbl%0d", r), lat, err_v, pass_v, exp_e);
      if (vec[r].exp_err >= 0) check($sformatf("tbl%0d_err", r), err_v, vec[r].exp_err);
      else check($sformatf("tbl%0d_err_nonzero", r), (err_v != 8'h00), 1);
      check($sformatf("tbl%0d_pass", r), pass_v, vec[r].exp_pass);
      check($sformatf("tbl%0d_done_level", r), done, 1);
    end

    // start pulsed mid-run must not disturb the run.
    build_model(8'h3C);
    do_run(8'h3C, 5, 1'b0, '0, 50, lat, err_v, pass_v);
    check_run("midstart", lat, err_v, pass_v, 0);

    // Reset in the middle of a high phase of an erroring run.
    tail_idx  = 3'd4;
    chain_inv = 1'b1;
    flip_mask = '0;
    @(negedge clk);
    seed  = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    check("prerst_gclk_high", gclk, 1);
    check("prerst_err_nonzero", (err_count != 8'h00), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_gclk", gclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err_count, 0);
    check("midrst_dout", d_out, 0);
    build_model(8'hA5);
    do_run(8'hA5, 5, 1'b0, '0, -1, lat, err_v, pass_v);
    check_run("postrst", lat, err_v, pass_v, 0);
    check("postrst_pass", pass_v, 1);

    // Randomized runs: random seed, chain length, inversion and sporadic tail corruption.
    for (int i = 0; i < 8; i++) begin
      s   = 8'($urandom);
      len = $urandom_range(DEPTH, 1);
      inv = 1'($urandom_range(1, 0));
      flips = '0;
      if ($urandom_range(1, 0) == 1)
        for (int k = 1; k <= NPULSE; k++) flips[k] = ($urandom_range(7, 0) == 0);
      build_model(s);
      exp_e = model_err(len, inv, flips);
      do_run(s, len, inv, flips, -1, lat, err_v, pass_v);
      check_run($sformatf("rnd%0d", i), lat, err_v, pass_v, exp_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2g_chain_sequencer.md
# l2g_chain_sequencer

Self-checking sequencer for the logic-to-global clock minitest. It generates a glitch-free, fabric-derived clock (`gclk_out`) for routing onto a global net and drives an LFSR data pattern into the head of an external register chain clocked by that net. It samples the chain tail, compares it against a delayed model of the pattern and reports pass/fail. It sits between the board I/O and the corner-placed register chain; the chain itself is external.

## Interface
- `DIV`, default 4: half-period of `gclk_out` in `clk` cycles; legal values are 2 and above.
- `DEPTH`, default 5: number of registers in the external chain, head to tail.
- `NPULSE`, default 64: rising edges of `gclk_out` per run; must be at least `DEPTH`.
- `clk`, in, 1: system clock; the only clock of this block.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle run request; honoured only in IDLE or DONE.
- `seed`, in, 8: LFSR seed, sampled on an accepted `start`.
- `gclk_out`, out, 1: registered derived clock for the global net.
- `d_out`, out, 1: data to the chain head.
- `q_in`, in, 1: chain tail. It is quasi-synchronous to `clk` and sampled only mid-period.
- `busy`, out, 1: high in LOAD and RUN.
- `done`, out, 1: level, high in DONE.
- `pass`, out, 1: valid while `done`; 1 iff `err_count` == 0.
- `err_count`, out, 8: mismatch count, saturating at 255.

## Operation
- States and transitions:
  - IDLE -> LOAD on `start`.
  - LOAD -> RUN unconditionally after 1 cycle.
  - RUN -> DONE after the falling toggle that follows rising edge `NPULSE`.
  - DONE -> LOAD on `start`.
- LOAD:
  - `lfsr` <= `seed`; a seed of 0 is replaced by 8'h01.
  - `divcnt`, `pulse_cnt`, `hist` and `err_count` are cleared.
  - `d_out` <= bit 0 of the loaded LFSR value.
- RUN:
  - `divcnt` counts 0..`DIV`-1 and wraps.
  - At wrap, `gclk_out` toggles.
- Rising toggle (0->1):
  - `pulse_cnt` increments.
  - `hist` <= {`hist`[`DEPTH`-2:0], `d_out`}. This models what the chain captures on that edge.
- Falling toggle (1->0):
  - LFSR advances: Fibonacci, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  - `d_out` <= new bit 0. Data therefore changes half a period away from the capturing edge.
  - If `pulse_cnt` >= `DEPTH`, compare `q_in` with `hist`[`DEPTH`-1]. A mismatch increments `err_count`, saturating.
- DONE:
  - `gclk_out` is held at 0 and `d_out` holds.
  - `pass` = (`err_count` == 0); `err_count` holds until the next LOAD.
- Comparisons per run: `NPULSE`-`DEPTH`+1, which is 60 with the defaults.
- `start` in LOAD or RUN is ignored, with no effect on any counter.

## Timing
- Reset values, taking effect on the same `clk` edge: state IDLE, `gclk_out`=0, `d_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `lfsr`=8'h01.
- Reset mid-RUN: `gclk_out` drops to 0 on that edge. A shortened high phase is acceptable only under reset.
- `busy` rises the cycle after `start` is sampled (LOAD).
- `gclk_out`:
  - First rising edge: registered `DIV`+1 cycles after `start` is sampled.
  - Period: exactly 2·`DIV` cycles and 50% duty; no runt pulses outside reset.
- `done` rises, and `busy` falls, 2·`DIV`·`NPULSE`+1 cycles after `start` is sampled; that is 513 with the defaults.
- `q_in` is sampled `DIV` cycles after the rising edge, giving a setup margin of ≥ `DIV`-1 `clk` cycles minus global skew. No synchroniser is required.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults, seed 8'hA5, 5-flop loopback chain on `gclk_out`:
  - `done` rises 513 cycles after `start`.
  - `pass`=1, `err_count`=0.
  - 64 rising edges of `gclk_out` counted.
- Same setup with an inverting tail (`q_in` = ~chain tail) -> `err_count`=60, `pass`=0.
- Seed 8'h00 -> `d_out` sequence identical to the run with seed 8'h01.
- `rst` asserted at cycle 200 of RUN:
  - Next edge: IDLE, `gclk_out`=0, `busy`=0, `err_count`=0.
  - A subsequent `start` completes with `pass`=1.
- `start` pulsed at cycle 50 of RUN -> ignored; `done` still rises at cycle 513 of the original run.
- Chain modelled as 4 flops with `DEPTH`=5:
  - `pass`=0 and `err_count` > 0.
  - Back-to-back restart from DONE with the correct 5-flop chain -> `err_count` cleared in LOAD, `pass`=1.
